// File: rtl/alu_sequencer.sv
// Fetch/decode/execute controller driving a combinational ALU, with an 8x16 register file.
// Optional SINGLE_STEP_EN adds a STEP input that gates each instruction fetch.
module alu_sequencer #(
  parameter int              PC_W   = 8,
  parameter logic [PC_W-1:0] RST_PC = '0
) (
  input  logic            CLK,
  input  logic            RST_N,
`ifdef SINGLE_STEP_EN
  input  logic            STEP,
`endif
  output logic            IM_REQ,
  output logic [PC_W-1:0] IM_ADDR,
  input  logic            IM_VALID,
  input  logic [15:0]     IM_DATA,
  output logic            ALU_EN,
  output logic            ALU_FLGON,
  output logic [2:0]      ALU_OP,
  output logic [15:0]     ALU_D1,
  output logic [15:0]     ALU_D2,
  input  logic [15:0]     ALU_RES,
  input  logic [1:0]      ALU_FLG,
  output logic [PC_W-1:0] PC_OUT,
  output logic [1:0]      FLAGS,
  output logic            HALTED,
  output logic            ILLEGAL
);

  typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_WB, S_HALT} state_e;

  state_e            state_q;
  logic [PC_W-1:0]   pc_q;
  logic [15:0]       ir_q;
  logic [7:0][15:0]  rf_q;
  logic [1:0]        flags_q;
  logic              im_req_q, alu_en_q, flgon_q, halted_q, ill_q;
  logic [2:0]        op_q;
  logic [15:0]       d1_q, d2_q;

  logic [3:0]        opc;
  logic [2:0]        rd, rs1, rs2;
  logic [PC_W-1:0]   tgt, pc_inc;
  logic              go;

  assign opc    = ir_q[15:12];
  assign rd     = ir_q[11:9];
  assign rs1    = ir_q[8:6];
  assign rs2    = ir_q[5:3];
  assign tgt    = ir_q[PC_W-1:0];
  assign pc_inc = pc_q + PC_W'(1);

`ifdef SINGLE_STEP_EN
  // A STEP seen while busy is remembered and spent on the next fetch.
  logic step_pend_q, arm;
  assign go  = STEP | step_pend_q;
  assign arm = (state_q == S_FETCH && !im_req_q) || (state_q == S_WB) ||
               (state_q == S_DECODE && opc > 4'd5 && opc != 4'hF);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N)         step_pend_q <= 1'b0;
    else if (arm && go) step_pend_q <= 1'b0;
    else if (STEP)      step_pend_q <= 1'b1;
  end
`else
  assign go = 1'b1;
`endif

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q  <= S_FETCH;
      pc_q     <= RST_PC;
      ir_q     <= '0;
      rf_q     <= '0;
      flags_q  <= '0;
      im_req_q <= 1'b0;
      alu_en_q <= 1'b0;
      flgon_q  <= 1'b0;
      op_q     <= '0;
      d1_q     <= '0;
      d2_q     <= '0;
      halted_q <= 1'b0;
      ill_q    <= 1'b0;
    end else begin
      ill_q <= 1'b0;
      case (state_q)
        S_FETCH: begin
          if (!im_req_q) begin
            if (go) im_req_q <= 1'b1;
          end else if (IM_VALID) begin
            ir_q     <= IM_DATA;
            im_req_q <= 1'b0;
            state_q  <= S_DECODE;
          end
        end
        S_DECODE: begin
          if (opc <= 4'd5) begin
            // ALU drive is registered here so it is stable for all of EXEC and WB.
            alu_en_q <= 1'b1;
            flgon_q  <= (opc == 4'd5);
            op_q     <= opc[2:0];
            d1_q     <= rf_q[rs1];
            d2_q     <= rf_q[rs2];
            state_q  <= S_EXEC;
          end else if (opc == 4'hF) begin
            halted_q <= 1'b1;
            state_q  <= S_HALT;
          end else begin
            state_q  <= S_FETCH;
            im_req_q <= go;
            pc_q     <= pc_inc;
            case (opc)
              4'd6:    rf_q[rd] <= {7'b0, ir_q[8:0]};
              4'd7:    if (flags_q[1]) pc_q <= tgt;
              4'd8:    if (flags_q[0]) pc_q <= tgt;
              4'd9:    pc_q <= tgt;
              default: ill_q <= 1'b1;
            endcase
          end
        end
        S_EXEC: state_q <= S_WB;
        S_WB: begin
          if (flgon_q) flags_q  <= ALU_FLG;
          else         rf_q[rd] <= ALU_RES;
          alu_en_q <= 1'b0;
          flgon_q  <= 1'b0;
          pc_q     <= pc_inc;
          im_req_q <= go;
          state_q  <= S_FETCH;
        end
        S_HALT:  ;
        default: state_q <= S_FETCH;
      endcase
    end
  end

  assign IM_REQ    = im_req_q;
  assign IM_ADDR   = pc_q;
  assign ALU_EN    = alu_en_q;
  assign ALU_FLGON = flgon_q;
  assign ALU_OP    = op_q;
  assign ALU_D1    = d1_q;
  assign ALU_D2    = d2_q;
  assign PC_OUT    = pc_q;
  assign FLAGS     = flags_q;
  assign HALTED    = halted_q;
  assign ILLEGAL   = ill_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer: instruction memory with programmable wait, behavioural ALU.
module tb_alu_sequencer;
  localparam int PC_W = 8;

  logic            CLK = 1'b0;
  logic            RST_N = 1'b0;
  logic            IM_REQ, IM_VALID;
  logic [PC_W-1:0] IM_ADDR, PC_OUT;
  logic [15:0]     IM_DATA, ALU_D1, ALU_D2, ALU_RES;
  logic            ALU_EN, ALU_FLGON, HALTED, ILLEGAL;
  logic [2:0]      ALU_OP;
  logic [1:0]      ALU_FLG, FLAGS;

  logic [15:0] imem [256];
  int          dly = 0;
  int          wcnt = 0;
  int          n_run = 0, n_fail = 0;
  logic [PC_W-1:0] fa [$];

  alu_sequencer #(.PC_W(PC_W), .RST_PC('0)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .IM_REQ(IM_REQ), .IM_ADDR(IM_ADDR), .IM_VALID(IM_VALID), .IM_DATA(IM_DATA),
    .ALU_EN(ALU_EN), .ALU_FLGON(ALU_FLGON), .ALU_OP(ALU_OP), .ALU_D1(ALU_D1), .ALU_D2(ALU_D2),
    .ALU_RES(ALU_RES), .ALU_FLG(ALU_FLG), .PC_OUT(PC_OUT), .FLAGS(FLAGS),
    .HALTED(HALTED), .ILLEGAL(ILLEGAL)
  );

  always #5 CLK = ~CLK;

  // Instruction memory answers after dly wait cycles of IM_REQ.
  assign IM_DATA  = imem[IM_ADDR];
  assign IM_VALID = IM_REQ && (wcnt >= dly);
  always @(posedge CLK) begin
    if (!RST_N || !IM_REQ || IM_VALID) wcnt <= 0;
    else                               wcnt <= wcnt + 1;
  end

  // Behavioural ALU; flags come from D1 - D2.
  logic [15:0] diff;
  always_comb begin
    diff = ALU_D1 - ALU_D2;
    case (ALU_OP)
      3'd0:    ALU_RES = ALU_D1 + ALU_D2;
      3'd1:    ALU_RES = diff;
      3'd2:    ALU_RES = ALU_D1 & ALU_D2;
      3'd3:    ALU_RES = ALU_D1 | ALU_D2;
      3'd4:    ALU_RES = ~ALU_D1;
      default: ALU_RES = 16'h0;
    endcase
    ALU_FLG = {diff == 16'h0, diff[15]};
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) imem[i] = 16'hF000;
  endtask

  task automatic do_reset();
    RST_N = 1'b0;
    fa.delete();
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    RST_N = 1'b1;
  endtask

  int          en_cnt, ill_cnt;
  logic [15:0] first_d1, first_d2;
  logic [2:0]  first_op;

  // Runs until HALTED; optionally rewrites address 0 once 0xFF has been fetched.
  task automatic run_to_halt(input int max, input bit patch0);
    bit seen = 0;
    en_cnt = 0; ill_cnt = 0;
    for (int c = 0; c < max; c++) begin
      @(negedge CLK);
      if (ALU_EN) begin
        if (en_cnt == 0) begin first_d1 = ALU_D1; first_d2 = ALU_D2; first_op = ALU_OP; end
        en_cnt++;
      end
      if (ILLEGAL) ill_cnt++;
      if (IM_REQ && IM_VALID) begin
        fa.push_back(IM_ADDR);
        if (patch0 && IM_ADDR == 8'hFF) imem[0] = 16'hF000;
      end
      if (HALTED) begin seen = 1; break; end
    end
    chk("halt_reached", seen, 1);
  endtask

  task automatic load_prog_a();
    clear_mem();
    imem[0] = 16'h6205;  // LDI r1,5
    imem[1] = 16'h6403;  // LDI r2,3
    imem[2] = 16'h0650;  // ADD r3,r1,r2
    imem[3] = 16'h1888;  // SUB r4,r2,r1
    imem[4] = 16'hF000;  // HALT
  endtask

  initial begin
    bit ok, seen;

    // Reset values
    clear_mem();
    RST_N = 1'b0;
    #1;
    chk("rst_im_req", IM_REQ, 0);
    chk("rst_alu_en", ALU_EN, 0);
    chk("rst_pc", PC_OUT, 0);
    chk("rst_flags_halt_ill", {FLAGS, HALTED, ILLEGAL}, 0);
    chk("rst_drive", {ALU_FLGON, ALU_OP, ALU_D1, ALU_D2}, 0);

    // Program A: arithmetic and halt
    load_prog_a();
    do_reset();
    run_to_halt(200, 0);
    chk("a_r3", dut.rf_q[3], 16'h0008);
    chk("a_r4", dut.rf_q[4], 16'hFFFE);
    chk("a_pc", PC_OUT, 4);
    chk("a_en_cycles", en_cnt, 4);
    chk("a_add_drive", {first_op, first_d1, first_d2}, {3'd0, 16'd5, 16'd3});
    repeat (3) @(negedge CLK);
    chk("a_halt_hold", {HALTED, IM_REQ, ALU_EN}, 3'b100);

    // Program B: equal compare, BEQ taken
    clear_mem();
    imem[0] = 16'h6207;  // LDI r1,7
    imem[1] = 16'h6407;  // LDI r2,7
    imem[2] = 16'h5050;  // CMP r1,r2
    imem[3] = 16'h7020;  // BEQ 0x20
    do_reset();
    run_to_halt(200, 0);
    chk("b_flags", FLAGS, 2'b10);
    chk("b_pc", PC_OUT, 8'h20);
    chk("b_fetch_after_beq", fa[fa.size()-1], 8'h20);

    // Program C: less-than compare, BEQ not taken, BLT taken
    clear_mem();
    imem[0] = 16'h6203;  // LDI r1,3
    imem[1] = 16'h6404;  // LDI r2,4
    imem[2] = 16'h5050;  // CMP r1,r2
    imem[3] = 16'h7030;  // BEQ 0x30
    imem[4] = 16'h8010;  // BLT 0x10
    do_reset();
    run_to_halt(200, 0);
    chk("c_flags", FLAGS, 2'b01);
    chk("c_beq_not_taken", (fa.size() > 5) ? fa[4] : 8'hEE, 8'h04);
    chk("c_blt_taken", (fa.size() > 5) ? fa[5] : 8'hEE, 8'h10);
    chk("c_pc", PC_OUT, 8'h10);

    // Delayed fetch: 5 wait cycles
    load_prog_a();
    dly = 5;
    do_reset();
    seen = 0;
    for (int c = 0; c < 10 && !seen; c++) begin
      @(negedge CLK);
      seen = IM_REQ;
    end
    chk("dly_req_seen", seen, 1);
    ok = 1;
    for (int i = 0; i < 6; i++) begin
      if (i > 0) @(negedge CLK);
      if (!(IM_REQ && IM_ADDR == 0 && PC_OUT == 0 && !ALU_EN)) ok = 0;
      if (IM_VALID != (i == 5)) ok = 0;
    end
    chk("dly_stable_6", ok, 1);
    @(negedge CLK);
    chk("dly_req_drop", IM_REQ, 0);
    run_to_halt(400, 0);
    chk("dly_r3", dut.rf_q[3], 16'h0008);
    chk("dly_r4", dut.rf_q[4], 16'hFFFE);
    chk("dly_pc", PC_OUT, 4);
    dly = 0;

    // Illegal opcode
    clear_mem();
    imem[0] = 16'h6209;  // LDI r1,9
    imem[1] = 16'hA000;  // illegal
    do_reset();
    run_to_halt(200, 0);
    chk("ill_pulses", ill_cnt, 1);
    chk("ill_regs", {dut.rf_q[0], dut.rf_q[1]}, {16'h0, 16'h0009});
    chk("ill_pc", PC_OUT, 2);
    chk("ill_no_alu", en_cnt, 0);

    // PC wrap at 0xFF
    clear_mem();
    imem[0]     = 16'h90FF;  // JMP 0xFF
    imem[8'hFF] = 16'h6A11;  // LDI r5,0x11
    do_reset();
    run_to_halt(200, 1);
    chk("wrap_r5", dut.rf_q[5], 16'h0011);
    chk("wrap_pc", PC_OUT, 0);
    chk("wrap_fetch", (fa.size() >= 2) ? {fa[fa.size()-2], fa[fa.size()-1]} : 16'hEEEE, 16'hFF00);

    // Reset during WB of ADD
    load_prog_a();
    do_reset();
    seen = 0;
    for (int c = 0; c < 50 && !seen; c++) begin
      @(negedge CLK);
      seen = ALU_EN;
    end
    chk("wbrst_exec_seen", seen, 1);
    @(negedge CLK);
    chk("wbrst_in_wb", ALU_EN, 1);
    RST_N = 1'b0;
    #1;
    chk("wbrst_outputs", {IM_REQ, ALU_EN, ALU_FLGON, HALTED, ILLEGAL, FLAGS}, 0);
    chk("wbrst_drive", {ALU_OP, ALU_D1, ALU_D2}, 0);
    chk("wbrst_pc", PC_OUT, 0);
    @(posedge CLK);
    #1;
    chk("wbrst_r3", dut.rf_q[3], 0);
    @(negedge CLK);
    RST_N = 1'b1;
    @(negedge CLK);
    chk("wbrst_r3_after", dut.rf_q[3], 0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule

// File: doc/alu_sequencer.md
Name: alu_sequencer

Overview:
- Fetch/decode/execute controller that initiates operations on the CPU's combinational ALU.
- Fetches 16-bit instructions from instruction memory over a req/valid handshake and keeps an 8x16 register file.
- Drives the ALU enable, flag-mode, opcode and operand inputs, then writes back the result or latches the compare flags.
- Consumes the flags for conditional branches.

Parameters:
- PC_W, 8, program counter / instruction address width (PC_W <= 12).
- RST_PC, 0, PC value loaded on reset.

Ports:
- CLK  input  1  system clock, rising edge
- RST_N  input  1  asynchronous active-low reset
- IM_REQ  output  1  instruction fetch request
- IM_ADDR  output  PC_W  fetch address
- IM_VALID  input  1  IM_DATA valid; ends the fetch
- IM_DATA  input  16  instruction word
- ALU_EN  output  1  ALU enable
- ALU_FLGON  output  1  1 = compare (flag) mode
- ALU_OP  output  3  ALU opcode
- ALU_D1  output  16  operand 1
- ALU_D2  output  16  operand 2
- ALU_RES  input  16  ALU result
- ALU_FLG  input  2  [0] = negative, [1] = zero
- PC_OUT  output  PC_W  current PC
- FLAGS  output  2  latched flags
- HALTED  output  1  core stopped
- ILLEGAL  output  1  one-cycle pulse on an undefined opcode

Behaviour:
- Reset (asynchronous, RST_N=0):
  - PC=RST_PC; regfile all 0; FLAGS=0; state FETCH.
  - IM_REQ=0, ALU_EN=0, ALU_FLGON=0, ALU_OP=0, ALU_D1=ALU_D2=0, HALTED=0, ILLEGAL=0.
  - Reset mid-fetch or mid-execute abandons the instruction: no writeback, no flag update.
- Instruction format: [15:12] opc, [11:9] rd, [8:6] rs1, [5:3] rs2, [8:0] imm9, [PC_W-1:0] target.
- Opcodes:
  - 0-4: ADD/SUB/AND/OR/NOT, rd <= ALU(rs1, rs2); ALU_OP = opc[2:0]. NOT uses rs1 only; D2 is driven with rs2 anyway.
  - 5 CMP: FLGON=1, D1=rs1, D2=rs2; FLAGS <= ALU_FLG; no register write.
  - 6 LDI: rd <= zero-extended imm9; ALU not used.
  - 7 BEQ: PC <= target if FLAGS[1]. 8 BLT: PC <= target if FLAGS[0]. 9 JMP: unconditional.
  - 15 HALT. 10-14 illegal.
- States: FETCH -> DECODE -> EXEC -> WB -> FETCH, plus HALT.
  - FETCH: IM_REQ=1, IM_ADDR=PC, held stable until a cycle with IM_VALID=1. IR captured on that edge; IM_REQ drops the next cycle. No timeout.
  - DECODE: reads operands; LDI, branch, HALT and illegal resolve here and skip EXEC/WB.
    - LDI writes rd and goes to FETCH with PC+1.
    - Branch loads the target or PC+1.
    - Illegal pulses ILLEGAL, treats the instruction as NOP, goes to FETCH with PC+1.
  - EXEC: ALU_EN=1; OP/FLGON/D1/D2 driven from IR/regfile.
  - WB: same drive held stable (ALU is combinational with an internal compare stage, so drive lasts two cycles). At the end of WB, ALU_RES -> rd or ALU_FLG -> FLAGS; PC <= PC+1. ALU_EN=0 from the next cycle.
  - Outside EXEC/WB, ALU_EN=0 and FLGON=0; OP/D1/D2 hold their last values.
- Latency: ALU op = fetch wait + 4 cycles (IM_VALID same cycle as IM_REQ gives 4 total); LDI, branch, illegal = fetch + 2.
- PC arithmetic is modulo 2^PC_W; PC+1 at the maximum wraps to 0. Target uses the low PC_W bits of IR[11:0].
- ALU result arithmetic is 16-bit wrap, taken from the ALU unchanged.
- rd == rs1/rs2 is legal: operands are read in DECODE/EXEC, the write happens at the end of WB.
- HALT: HALTED=1, IM_REQ=0, ALU_EN=0. Stays until reset.
- A branch uses FLAGS as latched at that point (the previous CMP).

Optional Feature:
- SINGLE_STEP_EN
- Defined: adds input STEP (1 bit). FETCH does not assert IM_REQ until a cycle with STEP=1 is seen; one instruction runs per STEP pulse. A STEP pulse that arrives during execution is held pending for the next fetch.
- Undefined: no STEP port; fetches are back-to-back.

Test Plan:
- Program LDI r1,5; LDI r2,3; ADD r3,r1,r2; SUB r4,r2,r1; HALT:
  - r3=8, r4=0xFFFE.
  - HALTED=1 with PC_OUT=4.
  - ALU_EN high exactly 4 cycles in total.
- LDI r1,7; LDI r2,7; CMP r1,r2; BEQ 0x20 -> FLAGS=2'b10, next IM_ADDR=0x20.
- CMP with r1=3, r2=4 -> FLAGS=2'b01; a following BEQ is not taken (IM_ADDR = PC+1); BLT 0x10 is taken.
- IM_VALID delayed 5 cycles -> IM_REQ/IM_ADDR stable for all 6 cycles; no state advance; results unchanged.
- Opcode 0xA -> ILLEGAL one-cycle pulse; no register change; PC+1.
- PC at 0xFF with PC_W=8 wraps to 0x00.
- RST_N asserted during WB of ADD -> rd unchanged (0); PC=RST_PC; all outputs at reset values immediately.
